// File: rtl/echo_detector.sv
// echo_detector: front-end control stage for the ultrasonic detection timer.
// It watches each transmit burst and the received-echo envelope. It pulses
// timerRST at burst launch and raises timerSTOP on the first confirmed echo
// or on timeout. Every output comes straight from a register.
module echo_detector #(
    parameter int DATA_W       = 12,
    parameter int BLANK_CYCLES = 64,
    parameter int CONFIRM_N    = 4,
    parameter int HYST         = 16,
    parameter int MAX_WAIT     = 1023
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic              ON,
    input  logic              TX_START,
    input  logic [DATA_W-1:0] ENV_DATA,
    input  logic              ENV_VALID,
    input  logic [DATA_W-1:0] THRESH,
    output logic              timerRST,
    output logic              timerSTOP,
    output logic              ECHO_FOUND,
    output logic              TIMEOUT
);

    localparam int EW = $clog2(MAX_WAIT + 1);

    // Last elapsed value spent in BLANK, and the elapsed value that triggers timeout.
    localparam logic [EW-1:0]     BLANK_LAST   = EW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [EW-1:0]     TMO_LAST     = EW'(MAX_WAIT - 1);
    localparam logic [EW-1:0]     ELAPSED_MAX  = '1;
    localparam logic [3:0]        CONFIRM_LAST = 4'(CONFIRM_N);
    localparam logic [DATA_W-1:0] HYST_W       = DATA_W'(HYST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_LISTEN,
        S_CONFIRM,
        S_DETECTED,
        S_TIMED_OUT
    } state_t;

    state_t              state_reg;
    logic [EW-1:0]       elapsed_reg;
    logic [3:0]          hit_reg;
    logic [DATA_W-1:0]   thr_reg;
    logic [DATA_W-1:0]   thr_lo_reg;
    logic                timer_rst_reg;
    logic                timer_stop_reg;
    logic                echo_found_reg;
    logic                timeout_reg;

    logic                armed;
    logic                above_hi;
    logic                above_lo;
    logic                detect_now;
    logic                timeout_now;
    logic [DATA_W-1:0]   thr_lo_next;

    // Decode this cycle's events: sample comparisons, confirmation and timeout.
    always_comb begin
        armed       = (state_reg == S_BLANK) || (state_reg == S_LISTEN) || (state_reg == S_CONFIRM);
        above_hi    = ENV_VALID && (ENV_DATA > thr_reg);
        above_lo    = ENV_VALID && (ENV_DATA > thr_lo_reg);
        thr_lo_next = (THRESH > HYST_W) ? (THRESH - HYST_W) : '0;
        detect_now  = 1'b0;
        // A single-hit configuration confirms on the very first sample above THR.
        if ((state_reg == S_LISTEN) && above_hi && (CONFIRM_N == 1)) begin
            detect_now = 1'b1;
        end
        if ((state_reg == S_CONFIRM) && above_lo && ((hit_reg + 4'd1) == CONFIRM_LAST)) begin
            detect_now = 1'b1;
        end
        timeout_now = armed && (elapsed_reg == TMO_LAST);
    end

    // Burst FSM and registered outputs. Priority: disable, launch, detect, timeout, progression.
    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            state_reg      <= S_IDLE;
            elapsed_reg    <= '0;
            hit_reg        <= '0;
            thr_reg        <= '0;
            thr_lo_reg     <= '0;
            timer_rst_reg  <= 1'b0;
            timer_stop_reg <= 1'b1;
            echo_found_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else if (!ON) begin
            // Disabled: behave as reset but keep the latched thresholds.
            state_reg      <= S_IDLE;
            elapsed_reg    <= '0;
            hit_reg        <= '0;
            timer_rst_reg  <= 1'b0;
            timer_stop_reg <= 1'b1;
            echo_found_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else if (TX_START) begin
            // Launch, or retrigger mid-burst: restart everything for the new burst.
            if (BLANK_CYCLES == 0) begin
                state_reg <= S_LISTEN;
            end else begin
                state_reg <= S_BLANK;
            end
            elapsed_reg    <= '0;
            hit_reg        <= '0;
            thr_reg        <= THRESH;
            thr_lo_reg     <= thr_lo_next;
            timer_rst_reg  <= 1'b1;
            timer_stop_reg <= 1'b0;
            echo_found_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            timer_rst_reg <= 1'b0;
            // The elapsed count saturates rather than wrapping.
            if (armed && (elapsed_reg != ELAPSED_MAX)) begin
                elapsed_reg <= elapsed_reg + EW'(1);
            end
            if (detect_now) begin
                state_reg      <= S_DETECTED;
                timer_stop_reg <= 1'b1;
                echo_found_reg <= 1'b1;
            end else if (timeout_now) begin
                state_reg      <= S_TIMED_OUT;
                timer_stop_reg <= 1'b1;
                timeout_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    S_BLANK: begin
                        if (elapsed_reg == BLANK_LAST) begin
                            state_reg <= S_LISTEN;
                        end
                    end
                    S_LISTEN: begin
                        if (above_hi) begin
                            hit_reg   <= 4'd1;
                            state_reg <= S_CONFIRM;
                        end
                    end
                    S_CONFIRM: begin
                        // Invalid cycles hold; a valid sample at or below THR_LO aborts the run.
                        if (above_lo) begin
                            hit_reg <= hit_reg + 4'd1;
                        end else if (ENV_VALID) begin
                            hit_reg   <= '0;
                            state_reg <= S_LISTEN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign timerRST   = timer_rst_reg;
    assign timerSTOP  = timer_stop_reg;
    assign ECHO_FOUND = echo_found_reg;
    assign TIMEOUT    = timeout_reg;

endmodule

// File: tb/tb_echo_detector.sv
// Directed testbench for echo_detector with default parameters
// (THRESH latched per burst, HYST=16, CONFIRM_N=4, BLANK_CYCLES=64, MAX_WAIT=1023).
// Inputs change on the falling edge; outputs are observed on the falling edge.
// cyc counts falling edges since the launch edge (cyc=1 is the first cycle after launch).
module tb_echo_detector;

    logic        SYS_CLK;
    logic        SYS_RST;
    logic        ON;
    logic        TX_START;
    logic [11:0] ENV_DATA;
    logic        ENV_VALID;
    logic [11:0] THRESH;
    logic        timerRST;
    logic        timerSTOP;
    logic        ECHO_FOUND;
    logic        TIMEOUT;

    int cyc;
    int tests_run;
    int tests_failed;

    echo_detector dut (
        .SYS_CLK   (SYS_CLK),
        .SYS_RST   (SYS_RST),
        .ON        (ON),
        .TX_START  (TX_START),
        .ENV_DATA  (ENV_DATA),
        .ENV_VALID (ENV_VALID),
        .THRESH    (THRESH),
        .timerRST  (timerRST),
        .timerSTOP (timerSTOP),
        .ECHO_FOUND(ECHO_FOUND),
        .TIMEOUT   (TIMEOUT)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    task automatic step();
        @(negedge SYS_CLK);
        cyc++;
    endtask

    // Pulse TX_START for one cycle; afterwards cyc=1 and the launch edge has occurred.
    task automatic launch(input logic [11:0] thr);
        TX_START = 1'b1;
        THRESH   = thr;
        step();
        TX_START = 1'b0;
        cyc      = 1;
    endtask

    // Drive a valid sample for the current cycle and advance one cycle.
    task automatic play(input int d);
        ENV_VALID = 1'b1;
        ENV_DATA  = 12'(d);
        step();
    endtask

    task automatic fill(input int target, input int d);
        while (cyc < target) play(d);
    endtask

    task automatic test_reset();
        SYS_RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            TX_START  = i[0];
            ON        = ~i[1];
            ENV_VALID = i[0];
            ENV_DATA  = 12'(300 * i);
            step();
            tests_run++;
            if ({timerRST, timerSTOP, ECHO_FOUND, TIMEOUT} !== 4'b0100) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: outputs=%b expected 0100", i, {timerRST, timerSTOP, ECHO_FOUND, TIMEOUT});
            end
        end
        TX_START = 1'b0;
        ON       = 1'b1;
        SYS_RST  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ENV_VALID = i[0];
            ENV_DATA  = 12'(500 + i);
            step();
            tests_run++;
            if ({timerRST, timerSTOP, ECHO_FOUND, TIMEOUT} !== 4'b0100) begin
                tests_failed++;
                $display("FAIL idle_no_pulse[%0d]: outputs=%b expected 0100", i, {timerRST, timerSTOP, ECHO_FOUND, TIMEOUT});
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_normal_echo();
        bit rst_seen;
        rst_seen = 1'b0;
        launch(12'd200);
        tests_run++;
        if (timerRST !== 1'b1 || timerSTOP !== 1'b0) begin
            tests_failed++;
            $display("FAIL launch_pulse: timerRST=%b timerSTOP=%b expected 1 0", timerRST, timerSTOP);
        end
        while (cyc < 100) begin
            play(30);
            if (timerRST !== 1'b0) rst_seen = 1'b1;
        end
        tests_run++;
        if (rst_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_one_cycle: timerRST seen high after cycle 1 (got %b expected 0)", rst_seen);
        end
        for (int i = 0; i < 3; i++) play(300);
        tests_run++;
        if (timerSTOP !== 1'b0 || ECHO_FOUND !== 1'b0) begin
            tests_failed++;
            $display("FAIL echo_early: cycle %0d timerSTOP=%b ECHO_FOUND=%b expected 0 0", cyc, timerSTOP, ECHO_FOUND);
        end
        play(300);
        tests_run++;
        if (timerSTOP !== 1'b1 || ECHO_FOUND !== 1'b1 || TIMEOUT !== 1'b0) begin
            tests_failed++;
            $display("FAIL echo_detect: cycle %0d stop=%b echo=%b tmo=%b expected 1 1 0", cyc, timerSTOP, ECHO_FOUND, TIMEOUT);
        end
        $display("[TB] test_normal_echo done");
    endtask

    task automatic test_blanking();
        // Loud samples through blanking must be ignored; first LISTEN cycle is 65.
        launch(12'd200);
        tests_run++;
        if (ECHO_FOUND !== 1'b0 || timerRST !== 1'b1) begin
            tests_failed++;
            $display("FAIL blank_launch: echo=%b rst=%b expected 0 1", ECHO_FOUND, timerRST);
        end
        fill(68, 300);
        tests_run++;
        if (timerSTOP !== 1'b0) begin
            tests_failed++;
            $display("FAIL blank_early: cycle %0d timerSTOP=%b expected 0", cyc, timerSTOP);
        end
        play(300);
        tests_run++;
        if (timerSTOP !== 1'b1 || ECHO_FOUND !== 1'b1) begin
            tests_failed++;
            $display("FAIL blank_edge: cycle %0d stop=%b echo=%b expected 1 1", cyc, timerSTOP, ECHO_FOUND);
        end
        $display("[TB] test_blanking done");
    endtask

    task automatic test_hysteresis();
        int s1[6];
        int s3[9];
        s1 = '{250, 190, 150, 250, 250, 250};
        launch(12'd200);
        fill(80, 100);
        foreach (s1[i]) play(s1[i]);
        tests_run++;
        if (timerSTOP !== 1'b0) begin
            tests_failed++;
            $display("FAIL hyst_noise_early: cycle %0d timerSTOP=%b expected 0", cyc, timerSTOP);
        end
        play(250);
        tests_run++;
        if (timerSTOP !== 1'b1 || ECHO_FOUND !== 1'b1) begin
            tests_failed++;
            $display("FAIL hyst_noise_detect: cycle %0d stop=%b echo=%b expected 1 1", cyc, timerSTOP, ECHO_FOUND);
        end
        // 190 is above THR_LO=184 and keeps the run alive.
        launch(12'd200);
        fill(80, 100);
        play(250); play(190); play(250);
        tests_run++;
        if (timerSTOP !== 1'b0) begin
            tests_failed++;
            $display("FAIL hyst_keep_early: cycle %0d timerSTOP=%b expected 0", cyc, timerSTOP);
        end
        play(250);
        tests_run++;
        if (timerSTOP !== 1'b1 || ECHO_FOUND !== 1'b1) begin
            tests_failed++;
            $display("FAIL hyst_keep_detect: cycle %0d stop=%b echo=%b expected 1 1", cyc, timerSTOP, ECHO_FOUND);
        end
        // 200 == THR never starts a run; 184 == THR_LO breaks one.
        s3 = '{200, 200, 200, 200, 250, 184, 250, 250, 250};
        launch(12'd200);
        fill(80, 100);
        foreach (s3[i]) play(s3[i]);
        tests_run++;
        if (timerSTOP !== 1'b0 || ECHO_FOUND !== 1'b0) begin
            tests_failed++;
            $display("FAIL thr_boundary: cycle %0d stop=%b echo=%b expected 0 0", cyc, timerSTOP, ECHO_FOUND);
        end
        play(250);
        tests_run++;
        if (timerSTOP !== 1'b1 || ECHO_FOUND !== 1'b1) begin
            tests_failed++;
            $display("FAIL thr_boundary_detect: cycle %0d stop=%b echo=%b expected 1 1", cyc, timerSTOP, ECHO_FOUND);
        end
        $display("[TB] test_hysteresis done");
    endtask

    task automatic test_timeout();
        launch(12'd200);
        fill(1023, 100);
        tests_run++;
        if (TIMEOUT !== 1'b0 || timerSTOP !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_early: cycle %0d tmo=%b stop=%b expected 0 0", cyc, TIMEOUT, timerSTOP);
        end
        play(100);
        tests_run++;
        if (TIMEOUT !== 1'b1 || timerSTOP !== 1'b1 || ECHO_FOUND !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_fire: cycle %0d tmo=%b stop=%b echo=%b expected 1 1 0", cyc, TIMEOUT, timerSTOP, ECHO_FOUND);
        end
        fill(1030, 300);
        tests_run++;
        if (TIMEOUT !== 1'b1 || timerSTOP !== 1'b1 || ECHO_FOUND !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_hold: cycle %0d tmo=%b stop=%b echo=%b expected 1 1 0", cyc, TIMEOUT, timerSTOP, ECHO_FOUND);
        end
        $display("[TB] test_timeout done");
    endtask

    task automatic test_timeout_tie();
        launch(12'd200);
        tests_run++;
        if (TIMEOUT !== 1'b0 || timerSTOP !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_clear: tmo=%b stop=%b expected 0 0", TIMEOUT, timerSTOP);
        end
        fill(1020, 100);
        play(300); play(300); play(300);
        tests_run++;
        if (ECHO_FOUND !== 1'b0 || TIMEOUT !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_early: cycle %0d echo=%b tmo=%b expected 0 0", cyc, ECHO_FOUND, TIMEOUT);
        end
        play(300);
        tests_run++;
        if (ECHO_FOUND !== 1'b1 || TIMEOUT !== 1'b0 || timerSTOP !== 1'b1) begin
            tests_failed++;
            $display("FAIL tie_detect_wins: cycle %0d echo=%b tmo=%b stop=%b expected 1 0 1", cyc, ECHO_FOUND, TIMEOUT, timerSTOP);
        end
        $display("[TB] test_timeout_tie done");
    endtask

    task automatic test_retrigger();
        launch(12'd200);
        fill(80, 100);
        play(300); play(300);
        // Now in CONFIRM with two hits; retrigger while loud samples continue.
        ENV_VALID = 1'b1;
        ENV_DATA  = 12'd300;
        launch(12'd200);
        tests_run++;
        if (timerRST !== 1'b1 || timerSTOP !== 1'b0 || ECHO_FOUND !== 1'b0 || TIMEOUT !== 1'b0) begin
            tests_failed++;
            $display("FAIL retrig_launch: rst=%b stop=%b echo=%b tmo=%b expected 1 0 0 0", timerRST, timerSTOP, ECHO_FOUND, TIMEOUT);
        end
        fill(68, 300);
        tests_run++;
        if (timerSTOP !== 1'b0 || ECHO_FOUND !== 1'b0) begin
            tests_failed++;
            $display("FAIL retrig_blank: cycle %0d stop=%b echo=%b expected 0 0", cyc, timerSTOP, ECHO_FOUND);
        end
        play(300);
        tests_run++;
        if (timerSTOP !== 1'b1 || ECHO_FOUND !== 1'b1) begin
            tests_failed++;
            $display("FAIL retrig_detect: cycle %0d stop=%b echo=%b expected 1 1", cyc, timerSTOP, ECHO_FOUND);
        end
        $display("[TB] test_retrigger done");
    endtask

    task automatic test_enable();
        launch(12'd200);
        fill(70, 100);
        ON = 1'b0;
        step();
        tests_run++;
        if ({timerRST, timerSTOP, ECHO_FOUND, TIMEOUT} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL on_low_idle: outputs=%b expected 0100", {timerRST, timerSTOP, ECHO_FOUND, TIMEOUT});
        end
        TX_START = 1'b1;
        step();
        TX_START = 1'b0;
        tests_run++;
        if (timerRST !== 1'b0 || timerSTOP !== 1'b1) begin
            tests_failed++;
            $display("FAIL on_low_tx_ignored: rst=%b stop=%b expected 0 1", timerRST, timerSTOP);
        end
        ON = 1'b1;
        for (int i = 0; i < 10; i++) play(300);
        tests_run++;
        if ({timerRST, timerSTOP, ECHO_FOUND, TIMEOUT} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL idle_ignores_env: outputs=%b expected 0100", {timerRST, timerSTOP, ECHO_FOUND, TIMEOUT});
        end
        $display("[TB] test_enable done");
    endtask

    task automatic test_async_reset();
        launch(12'd200);
        tests_run++;
        if (timerRST !== 1'b1 || timerSTOP !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_reset: rst=%b stop=%b expected 1 0", timerRST, timerSTOP);
        end
        #1 SYS_RST = 1'b0;
        #1;
        tests_run++;
        if ({timerRST, timerSTOP, ECHO_FOUND, TIMEOUT} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL async_reset: outputs=%b expected 0100", {timerRST, timerSTOP, ECHO_FOUND, TIMEOUT});
        end
        @(negedge SYS_CLK);
        SYS_RST = 1'b1;
        for (int i = 0; i < 5; i++) play(300);
        tests_run++;
        if ({timerRST, timerSTOP, ECHO_FOUND, TIMEOUT} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL post_reset_idle: outputs=%b expected 0100", {timerRST, timerSTOP, ECHO_FOUND, TIMEOUT});
        end
        launch(12'd200);
        tests_run++;
        if (timerRST !== 1'b1 || timerSTOP !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_launch: rst=%b stop=%b expected 1 0", timerRST, timerSTOP);
        end
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        cyc          = 0;
        tests_run    = 0;
        tests_failed = 0;
        SYS_RST      = 1'b0;
        ON           = 1'b0;
        TX_START     = 1'b0;
        ENV_DATA     = '0;
        ENV_VALID    = 1'b0;
        THRESH       = 12'd200;
        test_reset();
        test_normal_echo();
        test_blanking();
        test_hysteresis();
        test_timeout();
        test_timeout_tie();
        test_retrigger();
        test_enable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
